data_mem_bytelane: RTL and testbench

Parametrised data memory for the MIPS pipeline MEM stage and the successor to the word-only data RAM. Adds byte and halfword stores through byte-lane enables, and signed or unsigned sub-word loads. Read data is registered with a fixed one-cycle latency, and every access is checked for alignment. Little-endian lane order: byte 0 is bits [7:0].

---
 rtl/data_mem_bytelane.sv | 166 ++++++++++++++++
 tb/tb_data_mem_bytelane.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bytelane.sv
// Byte-lane data memory for the MEM stage: sb/sh/sw stores, sign- or
// zero-extended lb/lbu/lh/lhu/lw loads, registered read data with one-cycle
// latency, and per-request alignment checking. Little-endian lane order.
module data_mem_bytelane #(
  parameter int unsigned ADR_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [ADR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_write,
  output logic [DATA_WIDTH-1:0] data_read,
  output logic                  rdata_valid,
  output logic                  err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Elaboration-time parameter legality
  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("data_mem_bytelane: DATA_WIDTH must be 32");
  end
  if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > ADR_WIDTH - 2) begin : g_bad_depth
    $error("data_mem_bytelane: DEPTH_LOG2 must be in 2..ADR_WIDTH-2");
  end

  // Address bits above the word index only alias; they are intentionally dropped
  if (ADR_WIDTH > DEPTH_LOG2 + 2) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^addr[ADR_WIDTH-1:DEPTH_LOG2+2];
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [DATA_WIDTH-1:0] r_data_read;
  logic                  r_rdata_valid;
  logic                  r_err;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_off;
  logic                  w_req;
  logic                  w_misalign;
  logic                  w_conflict;
  logic                  w_reject;
  logic                  w_do_write;
  logic                  w_do_read;
  logic [LANES-1:0]      w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_idx = addr[DEPTH_LOG2+1:2];
  assign w_off = addr[1:0];

  // Size/alignment legality of the current request
  always_comb begin
    w_misalign = 1'b0;
    case (size)
      SZ_BYTE: w_misalign = 1'b0;
      SZ_HALF: w_misalign = w_off[0];
      SZ_WORD: w_misalign = |w_off;
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_req      = MemRead | MemWrite;
  assign w_conflict = MemRead & MemWrite;
  assign w_reject   = w_req & (w_misalign | w_conflict);
  assign w_do_write = MemWrite & ~w_reject;
  assign w_do_read  = MemRead & ~w_reject;

  // Lane enables and store data replicated onto every lane it may land in
  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    case (size)
      SZ_BYTE: begin
        w_be    = 4'(4'b0001 << w_off);
        w_wdata = {4{data_write[7:0]}};
      end
      SZ_HALF: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{data_write[15:0]}};
      end
      SZ_WORD: begin
        w_be    = 4'b1111;
        w_wdata = data_write;
      end
      default: begin
        w_be    = '0;
        w_wdata = '0;
      end
    endcase
  end

  // Storage array: contents survive reset, but no lane is written while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // contents retained; write blocked
    end else if (w_do_write) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = 8'(w_word >> {w_off, 3'b000});
  assign w_half = 16'(w_word >> {w_off[1], 4'b0000});

  // Lane extraction and sign/zero extension of the load result
  always_comb begin
    w_load = w_word;
    case (size)
      SZ_BYTE: begin
        if (unsigned_ld) begin
          w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
        end else begin
          w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
        end
      end
      SZ_HALF: begin
        if (unsigned_ld) begin
          w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
        end else begin
          w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
        end
      end
      default: w_load = w_word;
    endcase
  end

  // Registered response: load data, valid pulse and reject pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_read   <= '0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_err         <= w_reject;
      r_rdata_valid <= w_do_read;
      if (w_do_read) begin
        r_data_read <= w_load;
      end
    end
  end

  assign data_read   = r_data_read;
  assign rdata_valid = r_rdata_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Self-checking bench for data_mem_bytelane: directed spec scenarios plus
// randomized traffic checked against a byte-addressed reference model.
module tb_data_mem_bytelane;

  localparam int unsigned AW        = 32;
  localparam int unsigned DL2       = 6;
  localparam int unsigned MEM_BYTES = 4 << DL2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic        rdata_valid;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Reference model: flat byte array plus expected registered outputs
  logic [7:0]  mm [MEM_BYTES];
  logic [31:0] exp_data;
  logic        exp_valid;
  logic        exp_err;

  data_mem_bytelane #(
    .ADR_WIDTH (AW),
    .DEPTH_LOG2(DL2),
    .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .size       (size),
    .unsigned_ld(unsigned_ld),
    .addr       (addr),
    .data_write (data_write),
    .data_read  (data_read),
    .rdata_valid(rdata_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Byte-level behaviour of one request, applied at the clock edge
  function automatic void model_step(input logic rd, input logic wr, input logic [1:0] sz,
                                     input logic uns, input logic [31:0] a, input logic [31:0] d);
    int n;
    int base;
    logic [31:0] v;
    bit rej;
    if (!rd && !wr) begin
      exp_err   = 1'b0;
      exp_valid = 1'b0;
      return;
    end
    if (sz == 2'd3) begin
      rej = 1'b1;
      n   = 0;
    end else begin
      n   = 1 << sz;
      rej = ((a % n) != 0) || (rd && wr);
    end
    exp_err   = rej;
    exp_valid = !rej && rd;
    if (rej) return;
    base = int'(a % MEM_BYTES);
    if (wr) begin
      for (int i = 0; i < n; i++) mm[base+i] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mm[base+i];
      if (!uns && n < 4 && v[8*n-1] === 1'b1) begin
        for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      end
      exp_data = v;
    end
  endfunction

  // Drive one request for one cycle; returns #1 after the capturing edge
  task automatic cyc(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] d);
    MemRead     = rd;
    MemWrite    = wr;
    size        = sz;
    unsigned_ld = uns;
    addr        = a;
    data_write  = d;
    model_step(rd, wr, sz, uns, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; size = 2'd0; unsigned_ld = 1'b0;
    addr = '0; data_write = '0;
    exp_data = '0; exp_valid = 1'b0; exp_err = 1'b0;
    #2;
    total++; if (data_read !== 32'h0) begin bad++; $display("FAIL reset.data got=%h want=%h", data_read, 32'h0); end
    total++; if (rdata_valid !== 1'b0) begin bad++; $display("FAIL reset.valid got=%b want=0", rdata_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset.err got=%b want=0", err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word;
    cyc(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    total++; if (err !== 1'b0 || rdata_valid !== 1'b0) begin bad++; $display("FAIL word.store err=%b valid=%b want 0 0", err, rdata_valid); end
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    total++; if (data_read !== 32'hDEADBEEF) begin bad++; $display("FAIL word.data got=%h want=%h", data_read, 32'hDEADBEEF); end
    total++; if (rdata_valid !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL word.flags valid=%b err=%b want 1 0", rdata_valid, err); end
  endtask

  task automatic test_byte_lanes;
    cyc(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
    cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'h20, 32'hFFFFFF11);
    cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'hAAAAAA22);
    cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'h22, 32'h55555533);
    cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'h23, 32'h00000044);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    total++; if (data_read !== 32'h44332211) begin bad++; $display("FAIL lanes.sb got=%h want=%h", data_read, 32'h44332211); end
    cyc(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h9999ABCD);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    total++; if (data_read !== 32'hABCD2211) begin bad++; $display("FAIL lanes.sh got=%h want=%h", data_read, 32'hABCD2211); end
  endtask

  task automatic test_extension;
    logic [1:0]  t_sz  [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    logic        t_uns [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_a   [5] = '{32'h20, 32'h20, 32'h21, 32'h22, 32'h22};
    logic [31:0] t_exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFF80FF, 32'h000080FF};
    cyc(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F80);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, t_sz[i], t_uns[i], t_a[i], 32'h0);
      total++;
      if (data_read !== t_exp[i] || rdata_valid !== 1'b1) begin
        bad++;
        $display("FAIL ext[%0d] got=%h valid=%b want=%h valid=1", i, data_read, rdata_valid, t_exp[i]);
      end
    end
  endtask

  task automatic test_reject;
    logic        t_rd  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        t_wr  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  t_sz  [7] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
    logic [31:0] t_a   [7] = '{32'h21, 32'h20, 32'h22, 32'h20, 32'h20, 32'h21, 32'h20};
    logic        t_err [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        t_val [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_dat [7] = '{32'h000080FF, 32'h80FF7F80, 32'h80FF7F80, 32'h80FF7F80,
                               32'h80FF7F80, 32'h80FF7F80, 32'h80FF7F80};
    for (int i = 0; i < 7; i++) begin
      cyc(t_rd[i], t_wr[i], t_sz[i], 1'b0, t_a[i], 32'h00001234);
      total++;
      if (err !== t_err[i] || rdata_valid !== t_val[i] || data_read !== t_dat[i]) begin
        bad++;
        $display("FAIL reject[%0d] got err=%b valid=%b data=%h want err=%b valid=%b data=%h",
                 i, err, rdata_valid, data_read, t_err[i], t_val[i], t_dat[i]);
      end
    end
  endtask

  task automatic test_alias;
    logic [31:0] val;
    logic [31:0] hi;
    cyc(1'b0, 1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h004, 32'h0);
    total++; if (data_read !== 32'hCAFEF00D) begin bad++; $display("FAIL alias.fixed got=%h want=%h", data_read, 32'hCAFEF00D); end
    for (int w = 0; w < 64; w++) begin
      val = $urandom();
      hi  = $urandom() & 32'hFFFFFF00;
      cyc(1'b0, 1'b1, 2'd2, 1'b0, hi | 32'(w * 4), val);
      hi  = $urandom() & 32'hFFFFFF00;
      cyc(1'b1, 1'b0, 2'd2, 1'b0, hi | 32'(w * 4), 32'h0);
      total++;
      if (data_read !== val || rdata_valid !== 1'b1) begin
        bad++;
        $display("FAIL alias.word[%0d] got=%h valid=%b want=%h valid=1", w, data_read, rdata_valid, val);
      end
    end
  endtask

  task automatic test_random;
    int r;
    logic rd, wr, uns;
    logic [1:0] sz;
    logic [31:0] a;
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 9);
      rd = (r <= 3) || (r == 9);
      wr = (r >= 4 && r <= 7) || (r == 9);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      a  = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      cyc(rd, wr, sz, uns, a, $urandom());
      total++;
      if (err !== exp_err || rdata_valid !== exp_valid || data_read !== exp_data) begin
        bad++;
        $display("FAIL random[%0d] got err=%b valid=%b data=%h want err=%b valid=%b data=%h",
                 k, err, rdata_valid, data_read, exp_err, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] sz;
    logic [31:0] a;
    for (int k = 0; k < 32; k++) begin
      sz = 2'($urandom_range(0, 2));
      a  = $urandom();
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
      cyc(1'b0, 1'b1, sz, 1'b0, a, $urandom());
      cyc(1'b1, 1'b0, 2'd2, 1'b0, {a[31:2], 2'b00}, 32'h0);
      total++;
      if (data_read !== exp_data || rdata_valid !== 1'b1 || err !== 1'b0) begin
        bad++;
        $display("FAIL b2b[%0d] got data=%h valid=%b err=%b want data=%h valid=1 err=0",
                 k, data_read, rdata_valid, err, exp_data);
      end
    end
  endtask

  task automatic test_reset_midload;
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    #2;
    rst_n = 1'b0;
    exp_data = '0; exp_valid = 1'b0; exp_err = 1'b0;
    #1;
    total++; if (data_read !== 32'h0 || rdata_valid !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL rst_mid.async got data=%h valid=%b err=%b want 0 0 0", data_read, rdata_valid, err);
    end
    // Requests during reset: must neither write nor respond
    MemRead = 1'b1; MemWrite = 1'b0; size = 2'd2; addr = 32'h20; data_write = 32'h0;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b1; data_write = 32'h55555555;
    @(posedge clk); #1;
    total++; if (rdata_valid !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL rst_mid.held got valid=%b err=%b want 0 0", rdata_valid, err);
    end
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (rdata_valid !== 1'b0 || data_read !== 32'h0) begin
      bad++; $display("FAIL rst_mid.stale got valid=%b data=%h want 0 00000000", rdata_valid, data_read);
    end
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    total++; if (data_read !== exp_data || rdata_valid !== 1'b1) begin
      bad++; $display("FAIL rst_mid.nowrite got=%h valid=%b want=%h valid=1", data_read, rdata_valid, exp_data);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_extension();
    test_reject();
    test_alias();
    test_random();
    test_back_to_back();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
